// File: rtl/dc_pkg.sv
// Shared types and Q1.15 helpers for the frame DC-removal stage.
// The sat_sub helper is used when the DC_SAT_EN build option is defined.
package dc_pkg;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT_MEAN = 2'd1,
    DRAIN     = 2'd2
  } state_t;

  localparam logic [15:0] Q15_MAX = 16'h7FFF;
  localparam logic [15:0] Q15_MIN = 16'h8000;

  // Exact a-b clamped to the signed range of a w-bit word (w <= 31).
  function automatic logic signed [31:0] sat_sub(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned      w);
    logic signed [31:0] d;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    d  = a - b;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (d > hi) return hi;
    if (d < lo) return lo;
    return d;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// The storage array carries no reset.
module frame_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/frame_dc_remover.sv
// Buffers one frame, captures its mean, then streams samples minus mean.
// Define DC_SAT_EN to saturate the difference; otherwise it wraps.
module frame_dc_remover
  import dc_pkg::*;
#(
  parameter int FRAME_LEN = 2048,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [DATA_W-1:0] data_in,
  output logic                     ready_in,
  input  logic                     mean_valid,
  input  logic signed [DATA_W-1:0] mean_in,
  output logic                     valid_out,
  output logic signed [DATA_W-1:0] data_out,
  input  logic                     ready_out,
  output logic                     frame_done
);

  state_t                    r_state, w_state_nxt;
  logic [ADDR_W-1:0]         r_wr_cnt;
  logic [ADDR_W:0]           r_rd_cnt;
  logic [ADDR_W-1:0]         r_out_cnt;
  logic signed [DATA_W-1:0]  r_mean;
  logic                      r_rd_vld_p1;
  logic signed [DATA_W-1:0]  r_skid [2];
  logic                      r_wp, r_rp;
  logic [1:0]                r_cnt;
  logic signed [DATA_W-1:0]  w_ram_q;
  logic signed [DATA_W-1:0]  w_res;
  logic                      w_wr, w_cap, w_rd_en, w_pop, w_last;

  always_comb begin
    w_state_nxt = r_state;
    ready_in    = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      FILL: begin
        ready_in = 1'b1;
        if (valid_in && r_wr_cnt == ADDR_W'(FRAME_LEN - 1)) w_state_nxt = WAIT_MEAN;
      end
      WAIT_MEAN: begin
        if (mean_valid) begin
          w_cap       = 1'b1;
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_last) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  assign w_wr       = valid_in && ready_in;
  assign valid_out  = (r_cnt != 2'd0);
  assign data_out   = r_skid[r_rp];
  assign w_pop      = valid_out && ready_out;
  assign w_last     = w_pop && (r_out_cnt == '1);
  assign frame_done = w_last;

  // Issue a read only if the skid buffer can absorb it along with anything in flight.
  assign w_rd_en = (r_state == DRAIN) && !r_rd_cnt[ADDR_W] &&
                   (({1'b0, r_cnt} + {2'b0, r_rd_vld_p1}) < (3'd2 + {2'b0, w_pop}));

  frame_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_wr),
    .i_waddr(r_wr_cnt),
    .i_wdata(data_in),
    .i_re   (w_rd_en),
    .i_raddr(r_rd_cnt[ADDR_W-1:0]),
    .o_rdata(w_ram_q)
  );

`ifdef DC_SAT_EN
  assign w_res = DATA_W'(sat_sub(32'(w_ram_q), 32'(r_mean), DATA_W));
`else
  assign w_res = w_ram_q - r_mean;
`endif

  // Stage p0: buffer read issue; stage p1: subtract and push into the skid buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FILL;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_out_cnt   <= '0;
      r_mean      <= '0;
      r_rd_vld_p1 <= 1'b0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_cnt       <= 2'd0;
      for (int i = 0; i < 2; i++) r_skid[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd_vld_p1 <= w_rd_en;
      if (w_wr) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_cap) r_mean <= mean_in;
      if (w_last) r_rd_cnt <= '0;
      else if (w_rd_en) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_pop) begin
        r_rp      <= ~r_rp;
        r_out_cnt <= r_out_cnt + 1'b1;
      end
      if (r_rd_vld_p1) begin
        r_skid[r_wp] <= w_res;
        r_wp         <= ~r_wp;
      end
      r_cnt <= r_cnt + {1'b0, r_rd_vld_p1} - {1'b0, w_pop};
    end
  end

endmodule
